// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two requesters, the shared RAM and ram_arbiter.
// The slave modport is the arbiter's view. The master modport is the environment's view:
// the requesters plus the RAM.
interface ram_arbiter_if #(
   parameter int AW = 15,
   parameter int DW = 16
);
   logic          a_req_i;
   logic          a_we_i;
   logic [AW-1:0] a_addr_i;
   logic [DW-1:0] a_wdata_i;
   logic          a_gnt_o;
   logic          a_rvalid_o;
   logic [DW-1:0] a_rdata_o;

   logic          b_req_i;
   logic          b_we_i;
   logic [AW-1:0] b_addr_i;
   logic [DW-1:0] b_wdata_i;
   logic          b_gnt_o;
   logic          b_rvalid_o;
   logic [DW-1:0] b_rdata_o;

   logic          ram_load_o;
   logic [AW-1:0] ram_addr_o;
   logic [DW-1:0] ram_data_o;
   logic [DW-1:0] ram_rdata_i;

   modport slave (
      input  a_req_i, a_we_i, a_addr_i, a_wdata_i,
      output a_gnt_o, a_rvalid_o, a_rdata_o,
      input  b_req_i, b_we_i, b_addr_i, b_wdata_i,
      output b_gnt_o, b_rvalid_o, b_rdata_o,
      output ram_load_o, ram_addr_o, ram_data_o,
      input  ram_rdata_i
   );

   modport master (
      output a_req_i, a_we_i, a_addr_i, a_wdata_i,
      input  a_gnt_o, a_rvalid_o, a_rdata_o,
      output b_req_i, b_we_i, b_addr_i, b_wdata_i,
      input  b_gnt_o, b_rvalid_o, b_rdata_o,
      input  ram_load_o, ram_addr_o, ram_data_o,
      output ram_rdata_i
   );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between port A (CPU) and port B (scan-out/DMA).
// Port A has fixed priority. After MAX_BURST contended A grants, one B grant is forced.
// Optional statistics counters are built when RAM_ARB_STATS_EN is defined.
//
// Handshake: a requester holds req/we/addr/wdata stable until it sees gnt. The access
// happens in the cycle gnt=1, which is combinational from req. Keeping req high after
// gnt issues another access. Read data is registered from the combinational RAM output
// at the grant edge and is flagged by a one-cycle rvalid pulse.
module ram_arbiter #(
   parameter int MAX_BURST = 4,
   parameter int AW        = 15,
   parameter int DW        = 16
) (
   input  logic           clk_i,
   input  logic           reset_ni,
   ram_arbiter_if.slave   bus
`ifdef RAM_ARB_STATS_EN
   ,
   output logic [15:0]    a_cnt_o,
   output logic [15:0]    b_cnt_o,
   output logic [15:0]    stall_cnt_o
`endif
);

   typedef enum logic {PRIO_A, PRIO_B} state_t;

   state_t     state, state_n;
   logic [3:0] burst_cnt, burst_cnt_n;
   logic       a_gnt, b_gnt;
   logic       a_win, b_win;
   logic       contended;

   assign contended = bus.a_req_i & bus.b_req_i;

   // Next-state, burst counting and priority resolution
   always_comb begin
      state_n     = state;
      burst_cnt_n = burst_cnt;
      a_win       = 1'b0;
      b_win       = 1'b0;
      case (state)
         PRIO_A: begin
            a_win = bus.a_req_i;
            b_win = bus.b_req_i & ~bus.a_req_i;
            if (contended) begin
               if (burst_cnt == 4'(MAX_BURST - 1)) begin
                  state_n     = PRIO_B;
                  burst_cnt_n = 4'd0;
               end else begin
                  burst_cnt_n = burst_cnt + 4'd1;
               end
            end else if (b_win) begin
               burst_cnt_n = 4'd0;
            end
         end
         PRIO_B: begin
            b_win = bus.b_req_i;
            a_win = bus.a_req_i & ~bus.b_req_i;
            // Stay here until B actually gets its slot
            if (b_win) begin
               state_n     = PRIO_A;
               burst_cnt_n = 4'd0;
            end
         end
         default: state_n = PRIO_A;
      endcase
   end

   // Grants are forced low while reset is asserted, so the RAM sees no load
   assign a_gnt = a_win & reset_ni;
   assign b_gnt = b_win & reset_ni;

   assign bus.a_gnt_o    = a_gnt;
   assign bus.b_gnt_o    = b_gnt;
   assign bus.ram_load_o = (a_gnt & bus.a_we_i) | (b_gnt & bus.b_we_i);
   assign bus.ram_addr_o = a_gnt ? bus.a_addr_i  : (b_gnt ? bus.b_addr_i  : '0);
   assign bus.ram_data_o = a_gnt ? bus.a_wdata_i : (b_gnt ? bus.b_wdata_i : '0);

   // Arbitration state register
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state     <= PRIO_A;
         burst_cnt <= 4'd0;
      end else begin
         state     <= state_n;
         burst_cnt <= burst_cnt_n;
      end
   end

   // Read return: capture RAM data at the read grant edge, pulse rvalid next cycle
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         bus.a_rvalid_o <= 1'b0;
         bus.b_rvalid_o <= 1'b0;
         bus.a_rdata_o  <= '0;
         bus.b_rdata_o  <= '0;
      end else begin
         bus.a_rvalid_o <= a_gnt & ~bus.a_we_i;
         bus.b_rvalid_o <= b_gnt & ~bus.b_we_i;
         if (a_gnt && !bus.a_we_i) bus.a_rdata_o <= bus.ram_rdata_i;
         if (b_gnt && !bus.b_we_i) bus.b_rdata_o <= bus.ram_rdata_i;
      end
   end

`ifdef RAM_ARB_STATS_EN
   logic stall;
   assign stall = (bus.a_req_i & ~a_gnt) | (bus.b_req_i & ~b_gnt);

   // Saturating grant and stall counters
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         a_cnt_o     <= 16'd0;
         b_cnt_o     <= 16'd0;
         stall_cnt_o <= 16'd0;
      end else begin
         if (a_gnt && a_cnt_o != 16'hFFFF)     a_cnt_o     <= a_cnt_o + 16'd1;
         if (b_gnt && b_cnt_o != 16'hFFFF)     b_cnt_o     <= b_cnt_o + 16'd1;
         if (stall && stall_cnt_o != 16'hFFFF) stall_cnt_o <= stall_cnt_o + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter.
// A behavioural model of the arbitration rules and a shadow memory predict the grants
// and the read data. A monitor compares every rvalid pulse against an expected queue.
module tb_ram_arbiter;
   localparam int MAX_BURST = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ram_arbiter_if #(.AW(15), .DW(16)) bus ();

`ifdef RAM_ARB_STATS_EN
   logic [15:0] a_cnt, b_cnt, stall_cnt;
`endif

   ram_arbiter #(.MAX_BURST(MAX_BURST), .AW(15), .DW(16)) dut (
      .clk_i       (clk),
      .reset_ni    (rst_n),
      .bus         (bus)
`ifdef RAM_ARB_STATS_EN
      ,
      .a_cnt_o     (a_cnt),
      .b_cnt_o     (b_cnt),
      .stall_cnt_o (stall_cnt)
`endif
   );

   // RAM behind the arbiter: combinational read, write at the clock edge
   logic [15:0] mem     [0:32767];
   logic [15:0] ref_mem [0:32767];
   assign bus.ram_rdata_i = mem[bus.ram_addr_o];
   always @(posedge clk) if (bus.ram_load_o) mem[bus.ram_addr_o] <= bus.ram_data_o;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Model of the arbitration rules: contended A grants since the last B grant,
   // and whether B is owed the next contended slot
   int streak = 0;
   bit owe_b  = 1'b0;

   logic [15:0] a_exp_q[$], b_exp_q[$];
   int          a_cyc_q[$], b_cyc_q[$];
   logic [15:0] a_last = 16'h0, b_last = 16'h0;
   logic [15:0] ea, eb;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic flag_fail(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: got event expected none (t=%0t)", name, $time);
   endtask

   // Drive one request cycle (entered at posedge+1), check grants and RAM-side outputs,
   // update the model, return at the next posedge+1
   task automatic do_cycle(input logic ar, input logic aw, input logic [14:0] aa,
                           input logic [15:0] ad, input logic br, input logic bw,
                           input logic [14:0] ba, input logic [15:0] bd,
                           output logic ag, output logic bg);
      logic eag, ebg, eload;
      logic [14:0] eaddr;
      bus.a_req_i = ar; bus.a_we_i = aw; bus.a_addr_i = aa; bus.a_wdata_i = ad;
      bus.b_req_i = br; bus.b_we_i = bw; bus.b_addr_i = ba; bus.b_wdata_i = bd;
      if (ar && br) begin
         eag = !owe_b;
         ebg = owe_b;
      end else begin
         eag = ar;
         ebg = br;
      end
      eload = (eag && aw) || (ebg && bw);
      eaddr = eag ? aa : (ebg ? ba : 15'h0);
      @(negedge clk);
      check("a_gnt", bus.a_gnt_o, eag);
      check("b_gnt", bus.b_gnt_o, ebg);
      check("ram_load", bus.ram_load_o, eload);
      check("ram_addr", bus.ram_addr_o, eaddr);
      if (eload || !(eag || ebg))
         check("ram_data", bus.ram_data_o, eload ? (eag ? ad : bd) : 16'h0);
      if (eag) begin
         if (aw) ref_mem[aa] = ad;
         else begin a_exp_q.push_back(ref_mem[aa]); a_cyc_q.push_back(cyc); end
         if (ar && br) begin
            streak++;
            if (streak == MAX_BURST) begin owe_b = 1'b1; streak = 0; end
         end
      end
      if (ebg) begin
         if (bw) ref_mem[ba] = bd;
         else begin b_exp_q.push_back(ref_mem[ba]); b_cyc_q.push_back(cyc); end
         owe_b  = 1'b0;
         streak = 0;
      end
      @(posedge clk);
      #1;
      ag = eag;
      bg = ebg;
   endtask

   task automatic model_reset();
      streak = 0;
      owe_b  = 1'b0;
      a_exp_q.delete(); b_exp_q.delete();
      a_cyc_q.delete(); b_cyc_q.delete();
      a_last = 16'h0;
      b_last = 16'h0;
   endtask

   task automatic idle_inputs();
      bus.a_req_i = 1'b0; bus.a_we_i = 1'b0; bus.a_addr_i = 15'h0; bus.a_wdata_i = 16'h0;
      bus.b_req_i = 1'b0; bus.b_we_i = 1'b0; bus.b_addr_i = 15'h0; bus.b_wdata_i = 16'h0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Monitor: every rvalid pulse must match the oldest expected read, one clock after grant
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.a_rvalid_o) begin
            if (a_exp_q.size() == 0) flag_fail("a_rvalid_unexpected");
            else begin
               ea = a_exp_q.pop_front();
               check("a_rdata", bus.a_rdata_o, ea);
               check("a_rvalid_latency", 32'(cyc - a_cyc_q.pop_front()), 1);
               a_last = ea;
            end
         end else begin
            check("a_rdata_hold", bus.a_rdata_o, a_last);
            if (a_cyc_q.size() > 0 && a_cyc_q[0] < cyc) begin
               flag_fail("a_rvalid_missing");
               void'(a_cyc_q.pop_front());
               void'(a_exp_q.pop_front());
            end
         end
         if (bus.b_rvalid_o) begin
            if (b_exp_q.size() == 0) flag_fail("b_rvalid_unexpected");
            else begin
               eb = b_exp_q.pop_front();
               check("b_rdata", bus.b_rdata_o, eb);
               check("b_rvalid_latency", 32'(cyc - b_cyc_q.pop_front()), 1);
               b_last = eb;
            end
         end else begin
            check("b_rdata_hold", bus.b_rdata_o, b_last);
            if (b_cyc_q.size() > 0 && b_cyc_q[0] < cyc) begin
               flag_fail("b_rvalid_missing");
               void'(b_cyc_q.pop_front());
               void'(b_exp_q.pop_front());
            end
         end
      end
   end

   logic        ag, bg, ar, aw, br, bw, apend, bpend;
   logic [14:0] aa, ba;
   logic [15:0] ad, bd;
   logic [9:0]  pat;

   initial begin
      for (int i = 0; i < 32768; i++) begin
         mem[i]     = 16'h0;
         ref_mem[i] = 16'h0;
      end
      mem[15'h4000]     = 16'h1234;
      ref_mem[15'h4000] = 16'h1234;

      // Reset values
      idle_inputs();
      rst_n = 1'b0;
      #2;
      bus.a_req_i = 1'b1;
      bus.b_req_i = 1'b1;
      #1;
      check("rst_a_gnt", bus.a_gnt_o, 0);
      check("rst_b_gnt", bus.b_gnt_o, 0);
      check("rst_ram_load", bus.ram_load_o, 0);
      check("rst_a_rvalid", bus.a_rvalid_o, 0);
      check("rst_b_rdata", bus.b_rdata_o, 0);
      do_reset();

      // Test 1: A write then A read of the same address
      do_cycle(1, 1, 15'h0010, 16'hBEEF, 0, 0, 15'h0, 16'h0, ag, bg);
      do_cycle(1, 0, 15'h0010, 16'h0000, 0, 0, 15'h0, 16'h0, ag, bg);
      // Test 2: B-only read of a preloaded word
      do_cycle(0, 0, 15'h0, 16'h0, 1, 0, 15'h4000, 16'h0, ag, bg);
      do_cycle(0, 0, 15'h0, 16'h0, 0, 0, 15'h0, 16'h0, ag, bg);

      // Test 3: both requesting every cycle, fixed pattern A,A,A,A,B repeating
      pat = 10'h0;
      for (int i = 0; i < 10; i++) begin
         do_cycle(1, 0, 15'(i), 16'h0, 1, 0, 15'(100 + i), 16'h0, ag, bg);
         pat = {pat[8:0], bg};
      end
      check("burst_pattern", pat, 10'b0000100001);

      // Test 4: same address, A writes while B reads; B sees the new data afterwards
      do_cycle(1, 1, 15'h0020, 16'h00AA, 1, 0, 15'h0020, 16'h0, ag, bg);
      check("t4_a_first", {ag, bg}, 2'b10);
      do_cycle(0, 0, 15'h0, 16'h0, 1, 0, 15'h0020, 16'h0, ag, bg);

      // Test 5: reach forced-B priority, then reset mid-cycle after a B read grant
      for (int i = 0; i < MAX_BURST; i++)
         do_cycle(1, 0, 15'h0001, 16'h0, 1, 0, 15'h0002, 16'h0, ag, bg);
      bus.a_req_i = 1'b1; bus.a_we_i = 1'b0; bus.a_addr_i = 15'h0001;
      bus.b_req_i = 1'b1; bus.b_we_i = 1'b0; bus.b_addr_i = 15'h4000;
      @(negedge clk);
      check("t5_b_gnt", bus.b_gnt_o, 1);
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      check("t5_a_gnt_rst", bus.a_gnt_o, 0);
      check("t5_b_gnt_rst", bus.b_gnt_o, 0);
      check("t5_load_rst", bus.ram_load_o, 0);
      check("t5_addr_rst", bus.ram_addr_o, 0);
      check("t5_a_rvalid_rst", bus.a_rvalid_o, 0);
      check("t5_a_rdata_rst", bus.a_rdata_o, 0);
      check("t5_b_rdata_rst", bus.b_rdata_o, 0);
      idle_inputs();
      @(posedge clk);
      #1;
      check("t5_b_rvalid_dropped", bus.b_rvalid_o, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      pat = 10'h0;
      for (int i = 0; i < 5; i++) begin
         do_cycle(1, 0, 15'h0003, 16'h0, 1, 0, 15'h0004, 16'h0, ag, bg);
         pat = {pat[8:0], bg};
      end
      check("t5_prio_a_after_reset", pat, 10'b0000000001);

      // Randomized traffic on a small address window, honouring hold-until-grant
      apend = 1'b0;
      bpend = 1'b0;
      ar = 0; aw = 0; aa = 0; ad = 0; br = 0; bw = 0; ba = 0; bd = 0;
      for (int i = 0; i < 400; i++) begin
         if (!apend) begin
            ar = ($urandom_range(0, 99) < 70);
            aw = 1'($urandom_range(0, 1));
            aa = 15'($urandom_range(0, 15));
            ad = 16'($urandom);
         end
         if (!bpend) begin
            br = ($urandom_range(0, 99) < 70);
            bw = 1'($urandom_range(0, 1));
            ba = 15'($urandom_range(0, 15));
            bd = 16'($urandom);
         end
         do_cycle(ar, aw, aa, ad, br, bw, ba, bd, ag, bg);
         apend = ar && !ag;
         bpend = br && !bg;
      end
      do_cycle(0, 0, 15'h0, 16'h0, 0, 0, 15'h0, 16'h0, ag, bg);
      do_cycle(0, 0, 15'h0, 16'h0, 0, 0, 15'h0, 16'h0, ag, bg);
      check("a_queue_drained", a_exp_q.size(), 0);
      check("b_queue_drained", b_exp_q.size(), 0);

`ifdef RAM_ARB_STATS_EN
      // Test 6: ten fully contended cycles from reset
      do_reset();
      for (int i = 0; i < 10; i++)
         do_cycle(1, 0, 15'h0005, 16'h0, 1, 0, 15'h0006, 16'h0, ag, bg);
      check("stats_a_cnt", a_cnt, 16'd8);
      check("stats_b_cnt", b_cnt, 16'd2);
      check("stats_stall_cnt", stall_cnt, 16'd10);
      do_cycle(0, 0, 15'h0, 16'h0, 0, 0, 15'h0, 16'h0, ag, bg);
      do_cycle(0, 0, 15'h0, 16'h0, 0, 0, 15'h0, 16'h0, ag, bg);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
